pack_unsigned_stream: RTL

PACK_UNSIGNED_STREAM -- requirements
Module: pack_unsigned_stream

---
 rtl/leb128_pkg.sv | 16 +
 rtl/leb128_byte_form.sv | 14 +
 rtl/pack_unsigned_stream.sv | 97 +++++++++
 3 files changed

// File: rtl/leb128_pkg.sv
// Shared LEB128 definitions used by the encoder and decoder sides.
// MAX_BYTES gives the longest encoding of an n-bit unsigned value.
package leb128_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } leb_state_t;

    localparam int IDX_W = 3;

    function automatic int MAX_BYTES(input int n);
        return (n + 6) / 7;
    endfunction

endpackage

// File: rtl/leb128_byte_form.sv
// Splits a value into one LEB128 byte (continuation + low 7 bits) and the
// zero-filled residue that remains to be encoded.
module leb128_byte_form #(
    parameter int N = 32
) (
    input  logic [N-1:0] val_i,
    output logic [7:0]   byte_o,
    output logic [N-8:0] residue_o
);

    assign residue_o = val_i[N-1:7];
    assign byte_o    = {|val_i[N-1:7], val_i[6:0]};

endmodule

// File: rtl/pack_unsigned_stream.sv
// Streaming unsigned LEB128 encoder: accepts one N-bit value, emits its
// minimal byte sequence LSB group first over a valid/ready byte stream.
module pack_unsigned_stream
    import leb128_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [2:0]   out_idx,
    output logic         dbg_state_o
);

    // Handshake: a side transfers only in a cycle where its valid and ready are
    // both high; out_* hold steady while out_valid is high and out_ready is low.

    localparam int          MAXB    = MAX_BYTES(N);
    localparam logic [2:0]  IDX_MAX = 3'(MAXB - 1);

    leb_state_t   state_q, state_d;
    logic [7:0]   data_q, data_d;
    logic [2:0]   idx_q, idx_d;
    logic [N-8:0] res_q, res_d;
    logic         rdy_q;

    logic [N-1:0] form_val;
    logic [7:0]   form_byte;
    logic [N-8:0] form_res;
    logic         in_fire;
    logic         out_fire;

    assign out_valid   = (state_q == EMIT);
    assign out_data    = data_q;
    assign out_idx     = idx_q;
    assign out_last    = out_valid & ~data_q[7];
    assign dbg_state_o = (state_q == EMIT);

    // rdy_q holds in_ready low until the first clock edge after reset releases.
    assign in_ready = rdy_q & (~out_valid | (out_last & out_ready));
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // One byte former serves both a fresh load and the residue shift.
    assign form_val = in_fire ? in_data : {7'd0, res_q};

    leb128_byte_form #(.N(N)) u_form (
        .val_i     (form_val),
        .byte_o    (form_byte),
        .residue_o (form_res)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        res_d   = res_q;
        if (in_fire) begin
            state_d = EMIT;
            data_d  = form_byte;
            res_d   = form_res;
            idx_d   = 3'd0;
        end else if (out_fire && out_last) begin
            state_d = IDLE;
            data_d  = 8'd0;
            res_d   = '0;
            idx_d   = 3'd0;
        end else if (out_fire) begin
            data_d = form_byte;
            res_d  = form_res;
            idx_d  = (idx_q == IDX_MAX) ? idx_q : idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            data_q  <= 8'd0;
            idx_q   <= 3'd0;
            res_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule
